// File: rtl/vec_op_pkg.sv
// Shared types for the vector-op sequencer.
// Operation codes, FSM states and the drain counter width.
package vec_op_pkg;

    typedef enum logic [1:0] {
        OP_ADD  = 2'd0,
        OP_SUB  = 2'd1,
        OP_MAC  = 2'd2,
        OP_PASS = 2'd3
    } op_t;

    typedef enum logic [1:0] {
        IDLE,
        RUN,
        DRAIN,
        DONE
    } state_t;

    localparam int DRAIN_W = 4;

endpackage

// File: rtl/vec_lane_mask.sv
// Lane-valid mask for one group of LANES elements starting at i_base.
// One extra bit on the compare so a group near 2^IDX_W never wraps.
module vec_lane_mask
    import vec_op_pkg::*;
#(
    parameter int IDX_W = 8,
    parameter int LANES = 1
) (
    input  logic [IDX_W-1:0] i_base,
    input  logic [IDX_W-1:0] i_len,
    output logic [LANES-1:0] o_mask
);

    always_comb begin
        o_mask = '0;
        for (int i = 0; i < LANES; i++) begin
            o_mask[i] = ({1'b0, i_base} + (IDX_W+1)'(i)) < {1'b0, i_len};
        end
    end

endmodule

// File: rtl/vec_op_control.sv
// Element-wise vector op sequencer: index stepping, drain wait, done pulse.
// Define VEC_OP_ABORT_EN to add the abort input and aborted pulse output.
module vec_op_control
    import vec_op_pkg::*;
#(
    parameter int IDX_W    = 8,
    parameter int LANES    = 1,
    parameter int PIPE_LAT = 0
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             start,
    input  logic [IDX_W-1:0] len,
    input  logic [1:0]       mode,
    input  logic             stall,
`ifdef VEC_OP_ABORT_EN
    input  logic             abort,
    output logic             aborted,
`endif
    output logic [IDX_W-1:0] cur_idx,
    output logic [LANES-1:0] lane_mask,
    output logic [1:0]       op_sel,
    output logic             index_sel,
    output logic             write_s,
    output logic             busy,
    output logic             sum_ready
);

    localparam logic [IDX_W:0] LANES_W = (IDX_W+1)'(LANES);
    localparam logic [DRAIN_W-1:0] DRAIN_INIT =
        DRAIN_W'((PIPE_LAT > 0) ? PIPE_LAT - 1 : 0);

    state_t             r_state;
    logic [IDX_W-1:0]   r_cur;
    logic [IDX_W-1:0]   r_len;
    op_t                r_mode;
    logic [DRAIN_W-1:0] r_cnt;

    logic               w_run;
    logic               w_write;
    logic               w_last;
    logic               w_abort;
    logic [IDX_W:0]     w_next;
    logic [LANES-1:0]   w_mask;

    assign w_run   = (r_state == RUN);
    assign w_write = w_run & ~stall;
    assign w_next  = {1'b0, r_cur} + LANES_W;
    assign w_last  = !(w_next < {1'b0, r_len});

`ifdef VEC_OP_ABORT_EN
    logic r_aborted;
    assign w_abort = abort & ((r_state == RUN) | (r_state == DRAIN));
    assign aborted = r_aborted;
`else
    assign w_abort = 1'b0;
`endif

    vec_lane_mask #(
        .IDX_W (IDX_W),
        .LANES (LANES)
    ) u_mask (
        .i_base (r_cur),
        .i_len  (r_len),
        .o_mask (w_mask)
    );

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_state <= IDLE;
            r_cur   <= '0;
            r_len   <= '0;
            r_mode  <= OP_ADD;
            r_cnt   <= '0;
`ifdef VEC_OP_ABORT_EN
            r_aborted <= 1'b0;
`endif
        end else begin
`ifdef VEC_OP_ABORT_EN
            r_aborted <= 1'b0;
`endif
            // Abort wins over a final write landing in the same cycle.
            if (w_abort) begin
                r_state <= IDLE;
                r_cur   <= '0;
                r_cnt   <= '0;
`ifdef VEC_OP_ABORT_EN
                r_aborted <= 1'b1;
`endif
            end else begin
                unique case (r_state)
                    IDLE: begin
                        if (start) begin
                            r_len   <= len;
                            r_mode  <= op_t'(mode);
                            r_cur   <= '0;
                            r_state <= (len == '0) ? DONE : RUN;
                        end
                    end
                    RUN: begin
                        if (w_write) begin
                            if (w_last) begin
                                r_cur <= '0;
                                if (PIPE_LAT > 0) begin
                                    r_state <= DRAIN;
                                    r_cnt   <= DRAIN_INIT;
                                end else begin
                                    r_state <= DONE;
                                end
                            end else begin
                                r_cur <= w_next[IDX_W-1:0];
                            end
                        end
                    end
                    DRAIN: begin
                        if (r_cnt == '0) begin
                            r_state <= DONE;
                        end else begin
                            r_cnt <= r_cnt - 1'b1;
                        end
                    end
                    DONE: begin
                        r_state <= IDLE;
                    end
                    default: begin
                        r_state <= IDLE;
                    end
                endcase
            end
        end
    end

    assign cur_idx   = r_cur;
    assign lane_mask = w_run ? w_mask : '0;
    assign op_sel    = r_mode;
    assign index_sel = w_run;
    assign write_s   = w_write;
    assign busy      = (r_state != IDLE);
    assign sum_ready = (r_state == DONE);

endmodule

// File: tb/tb_vec_op_control.sv
// Directed table-driven bench for vec_op_control on three configurations.
// Covers the abort pulse when VEC_OP_ABORT_EN is defined.
module tb_vec_op_control;

    typedef struct {
        int   sel;
        bit   start;
        int   len;
        int   mode;
        bit   stall;
        int   e_idx;
        int   e_mask;
        bit   e_ws;
        bit   e_isel;
        bit   e_busy;
        bit   e_sr;
        int   e_op;
    } vec_t;

    logic clk = 1'b0;
    logic rst = 1'b1;

    logic       st    [3];
    logic [7:0] ln    [3];
    logic [1:0] md    [3];
    logic       sl    [3];
    logic [7:0] idx   [3];
    logic [3:0] msk   [3];
    logic [1:0] ops   [3];
    logic       isel  [3];
    logic       ws    [3];
    logic       bsy   [3];
    logic       sr    [3];
    logic [3:0] mask_a;
    logic [0:0] mask_b;
    logic [3:0] mask_c;

`ifdef VEC_OP_ABORT_EN
    logic ab  [3];
    logic abd [3];
`endif

    int n_run  = 0;
    int n_fail = 0;
    vec_t tbl[$];

    always #5 clk = ~clk;

    assign msk[0] = mask_a;
    assign msk[1] = {3'b000, mask_b};
    assign msk[2] = mask_c;

    vec_op_control #(.IDX_W(8), .LANES(4), .PIPE_LAT(2)) u_a (
        .clk(clk), .reset(rst), .start(st[0]), .len(ln[0]),
        .mode(md[0]), .stall(sl[0]),
`ifdef VEC_OP_ABORT_EN
        .abort(ab[0]), .aborted(abd[0]),
`endif
        .cur_idx(idx[0]), .lane_mask(mask_a), .op_sel(ops[0]),
        .index_sel(isel[0]), .write_s(ws[0]), .busy(bsy[0]),
        .sum_ready(sr[0])
    );

    vec_op_control #(.IDX_W(8), .LANES(1), .PIPE_LAT(0)) u_b (
        .clk(clk), .reset(rst), .start(st[1]), .len(ln[1]),
        .mode(md[1]), .stall(sl[1]),
`ifdef VEC_OP_ABORT_EN
        .abort(ab[1]), .aborted(abd[1]),
`endif
        .cur_idx(idx[1]), .lane_mask(mask_b), .op_sel(ops[1]),
        .index_sel(isel[1]), .write_s(ws[1]), .busy(bsy[1]),
        .sum_ready(sr[1])
    );

    vec_op_control #(.IDX_W(8), .LANES(4), .PIPE_LAT(0)) u_c (
        .clk(clk), .reset(rst), .start(st[2]), .len(ln[2]),
        .mode(md[2]), .stall(sl[2]),
`ifdef VEC_OP_ABORT_EN
        .abort(ab[2]), .aborted(abd[2]),
`endif
        .cur_idx(idx[2]), .lane_mask(mask_c), .op_sel(ops[2]),
        .index_sel(isel[2]), .write_s(ws[2]), .busy(bsy[2]),
        .sum_ready(sr[2])
    );

    task automatic chk(input string nm, input logic [31:0] act,
                       input logic [31:0] exp);
        n_run++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d", nm, act, exp);
        end
    endtask

    function automatic vec_t v(int sel, bit s, int l, int m, bit stl,
                               int ei, int em, bit ew, bit eis,
                               bit eb, bit es, int eo);
        vec_t r;
        r.sel = sel; r.start = s; r.len = l; r.mode = m; r.stall = stl;
        r.e_idx = ei; r.e_mask = em; r.e_ws = ew; r.e_isel = eis;
        r.e_busy = eb; r.e_sr = es; r.e_op = eo;
        return r;
    endfunction

    task automatic idle_inputs();
        for (int k = 0; k < 3; k++) begin
            st[k] = 1'b0; ln[k] = 8'd0; md[k] = 2'd0; sl[k] = 1'b0;
`ifdef VEC_OP_ABORT_EN
            ab[k] = 1'b0;
`endif
        end
    endtask

    task automatic chk_all(input int d, input string tag, input int ei,
                           input int em, input bit ew, input bit eis,
                           input bit eb, input bit es, input int eo);
        chk({tag, " idx"},  32'(idx[d]),  32'(ei));
        chk({tag, " mask"}, 32'(msk[d]),  32'(em));
        chk({tag, " ws"},   32'(ws[d]),   32'(ew));
        chk({tag, " isel"}, 32'(isel[d]), 32'(eis));
        chk({tag, " busy"}, 32'(bsy[d]),  32'(eb));
        chk({tag, " sr"},   32'(sr[d]),   32'(es));
        chk({tag, " op"},   32'(ops[d]),  32'(eo));
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "timeout");
    end

    initial begin
        int writes;
        bit seen;

        idle_inputs();

        // LANES=4 PIPE_LAT=2: len 10 SUB, stall/start ignored in DRAIN, len 0
        tbl.push_back(v(0,1,10,1,0, 0, 0,0,0,0,0,0));
        tbl.push_back(v(0,0, 0,0,0, 0,15,1,1,1,0,1));
        tbl.push_back(v(0,0, 0,0,0, 4,15,1,1,1,0,1));
        tbl.push_back(v(0,0, 0,0,0, 8, 3,1,1,1,0,1));
        tbl.push_back(v(0,0, 0,0,1, 0, 0,0,0,1,0,1));
        tbl.push_back(v(0,1, 5,0,1, 0, 0,0,0,1,0,1));
        tbl.push_back(v(0,0, 0,0,0, 0, 0,0,0,1,1,1));
        tbl.push_back(v(0,1, 0,3,0, 0, 0,0,0,0,0,1));
        tbl.push_back(v(0,0, 0,0,0, 0, 0,0,0,1,1,3));
        tbl.push_back(v(0,0, 0,0,0, 0, 0,0,0,0,0,3));
        // LANES=1 PIPE_LAT=0: len 3 MAC, start in RUN ignored, back-to-back
        tbl.push_back(v(1,1, 3,2,0, 0, 0,0,0,0,0,0));
        tbl.push_back(v(1,0, 0,0,0, 0, 1,1,1,1,0,2));
        tbl.push_back(v(1,1, 7,0,0, 1, 1,1,1,1,0,2));
        tbl.push_back(v(1,0, 0,0,0, 2, 1,1,1,1,0,2));
        tbl.push_back(v(1,0, 0,0,0, 0, 0,0,0,1,1,2));
        tbl.push_back(v(1,1, 2,3,0, 0, 0,0,0,0,0,2));
        tbl.push_back(v(1,0, 0,0,0, 0, 1,1,1,1,0,3));
        tbl.push_back(v(1,0, 0,0,0, 1, 1,1,1,1,0,3));
        tbl.push_back(v(1,0, 0,0,0, 0, 0,0,0,1,1,3));
        tbl.push_back(v(1,0, 0,0,0, 0, 0,0,0,0,0,3));
        // LANES=4 PIPE_LAT=0: len 8 with stall in cycles 2-3
        tbl.push_back(v(2,1, 8,0,0, 0, 0,0,0,0,0,0));
        tbl.push_back(v(2,0, 0,0,0, 0,15,1,1,1,0,0));
        tbl.push_back(v(2,0, 0,0,1, 4,15,0,1,1,0,0));
        tbl.push_back(v(2,0, 0,0,1, 4,15,0,1,1,0,0));
        tbl.push_back(v(2,0, 0,0,0, 4,15,1,1,1,0,0));
        tbl.push_back(v(2,0, 0,0,0, 0, 0,0,0,1,1,0));
        tbl.push_back(v(2,0, 0,0,0, 0, 0,0,0,0,0,0));

        #2;
        for (int k = 0; k < 3; k++) begin
            chk_all(k, $sformatf("reset d%0d", k), 0, 0, 0, 0, 0, 0, 0);
        end
        repeat (2) @(posedge clk);
        #1 rst = 1'b0;

        for (int r = 0; r < tbl.size(); r++) begin
            @(posedge clk);
            #1;
            idle_inputs();
            st[tbl[r].sel] = tbl[r].start;
            ln[tbl[r].sel] = 8'(tbl[r].len);
            md[tbl[r].sel] = 2'(tbl[r].mode);
            sl[tbl[r].sel] = tbl[r].stall;
            @(negedge clk);
            chk_all(tbl[r].sel, $sformatf("row%0d", r), tbl[r].e_idx,
                    tbl[r].e_mask, tbl[r].e_ws, tbl[r].e_isel,
                    tbl[r].e_busy, tbl[r].e_sr, tbl[r].e_op);
        end

        // len 255 on LANES=4: 64 groups, last at 252 with mask 0111
        @(posedge clk);
        #1;
        idle_inputs();
        st[2] = 1'b1; ln[2] = 8'd255; md[2] = 2'd3;
        @(posedge clk);
        #1 st[2] = 1'b0;
        writes = 0;
        for (int g = 0; g < 64; g++) begin
            @(negedge clk);
            chk($sformatf("max g%0d idx", g), 32'(idx[2]), 32'(4 * g));
            chk($sformatf("max g%0d mask", g), 32'(msk[2]),
                (g == 63) ? 32'd7 : 32'd15);
            if (ws[2] === 1'b1) writes++;
            @(posedge clk);
            #1;
        end
        @(negedge clk);
        chk("max writes", 32'(writes), 32'd64);
        chk("max sr", 32'(sr[2]), 32'd1);
        chk("max op", 32'(ops[2]), 32'd3);

        // async reset mid-RUN at cur_idx 4
        @(posedge clk);
        #1;
        st[0] = 1'b1; ln[0] = 8'd10; md[0] = 2'd2;
        @(posedge clk);
        #1 st[0] = 1'b0;
        @(posedge clk);
        #3;
        chk("prerst idx", 32'(idx[0]), 32'd4);
        rst = 1'b1;
        #1;
        chk_all(0, "midrst", 0, 0, 0, 0, 0, 0, 0);
        @(negedge clk);
        rst = 1'b0;
        seen = 1'b0;
        for (int c = 0; c < 8; c++) begin
            @(negedge clk);
            if (sr[0] !== 1'b0 || bsy[0] !== 1'b0) seen = 1'b1;
        end
        chk("postrst quiet", 32'(seen), 32'd0);

`ifdef VEC_OP_ABORT_EN
        // abort during DRAIN: one aborted pulse, no sum_ready
        @(posedge clk);
        #1;
        st[0] = 1'b1; ln[0] = 8'd4; md[0] = 2'd1;
        @(posedge clk);
        #1 st[0] = 1'b0;
        @(posedge clk);
        #1 ab[0] = 1'b1;
        @(negedge clk);
        chk("abort drain busy", 32'(bsy[0]), 32'd1);
        chk("abort pre", 32'(abd[0]), 32'd0);
        @(posedge clk);
        #1 ab[0] = 1'b0;
        @(negedge clk);
        chk("aborted pulse", 32'(abd[0]), 32'd1);
        chk("abort busy", 32'(bsy[0]), 32'd0);
        chk("abort sr", 32'(sr[0]), 32'd0);
        seen = 1'b0;
        for (int c = 0; c < 4; c++) begin
            @(negedge clk);
            if (sr[0] !== 1'b0 || abd[0] !== 1'b0) seen = 1'b1;
        end
        chk("abort quiet", 32'(seen), 32'd0);
`endif

        $display("[TB] %0d tests run, %0d failed", n_run, n_fail);
        $finish;
    end

endmodule
